// File: rtl/uart_tx_gen2.sv
// UART transmitter with a small transmit FIFO, optional parity and one or two stop bits.
// Line settings are captured when a word leaves the FIFO, so they hold for the whole frame.
module uart_tx_gen2 #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic [PRESCALE_WIDTH-1:0]     Prescale,
  input  logic                          Parity_EN,
  input  logic                          Parity_type,
  input  logic                          Stop2,
  input  logic                          Data_valid,
  input  logic [DATA_WIDTH-1:0]         Data,
  output logic                          Data_ready,
  output logic                          Tx_out,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [DATA_WIDTH-1:0]     head;
  logic                      push;
  logic                      pop;

  logic [2:0]                state;
  logic [PRESCALE_WIDTH-1:0] baud_cnt;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [BIT_W-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic                      parity_en_q;
  logic                      parity_bit_q;
  logic                      stop2_q;
  logic                      bit_done;
  logic                      last_stop;

  assign head       = mem[rd_ptr];
  assign Data_ready = (Fifo_count < CNT_W'(FIFO_DEPTH));
  assign push       = Data_valid & Data_ready;
  assign bit_done   = (baud_cnt == prescale_q);
  assign last_stop  = (state == STOP) && bit_done &&
                      (!stop2_q || (bit_cnt == BIT_W'(1)));
  // A new frame starts from IDLE or straight off the final stop bit, giving no idle gap.
  assign pop        = (Fifo_count != '0) && ((state == IDLE) || last_stop);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= Data;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   Fifo_count <= Fifo_count + 1'b1;
        2'b01:   Fifo_count <= Fifo_count - 1'b1;
        default: Fifo_count <= Fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      Tx_out       <= 1'b1;
      Busy         <= 1'b0;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      prescale_q   <= '0;
      parity_en_q  <= 1'b0;
      parity_bit_q <= 1'b0;
      stop2_q      <= 1'b0;
    end else if (pop) begin
      state        <= START;
      Tx_out       <= 1'b0;
      Busy         <= 1'b1;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_q      <= head;
      prescale_q   <= Prescale;
      parity_en_q  <= Parity_EN;
      parity_bit_q <= (^head) ^ Parity_type;
      stop2_q      <= Stop2;
    end else if (state == IDLE) begin
      Tx_out <= 1'b1;
      Busy   <= 1'b0;
    end else if (!bit_done) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      case (state)
        START: begin
          state   <= DATA;
          Tx_out  <= shift_q[0];
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (parity_en_q) begin
              state  <= PARITY;
              Tx_out <= parity_bit_q;
            end else begin
              state  <= STOP;
              Tx_out <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shift_q <= shift_q >> 1;
            Tx_out  <= shift_q[1];
          end
        end
        PARITY: begin
          state   <= STOP;
          Tx_out  <= 1'b1;
          bit_cnt <= '0;
        end
        STOP: begin
          // Second stop period only when two stop bits were latched for this frame.
          if (stop2_q && (bit_cnt == '0)) begin
            bit_cnt <= BIT_W'(1);
          end else begin
            state   <= IDLE;
            Tx_out  <= 1'b1;
            Busy    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          Tx_out <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Self-checking bench for uart_tx_gen2: a waveform-level reference model checked every cycle,
// a table of single-frame vectors, and hand-written multi-cycle corner sequences.
module tb_uart_tx_gen2;

  localparam int DW = 8;
  localparam int FD = 4;
  localparam int PW = 8;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic [PW-1:0] Prescale = '0;
  logic          Parity_EN = 1'b0;
  logic          Parity_type = 1'b0;
  logic          Stop2 = 1'b0;
  logic          Data_valid = 1'b0;
  logic [DW-1:0] Data = '0;
  logic          Data_ready;
  logic          Tx_out;
  logic          Busy;
  logic [2:0]    Fifo_count;

  int total = 0;
  int bad = 0;

  uart_tx_gen2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .Reset(Reset), .Prescale(Prescale), .Parity_EN(Parity_EN),
    .Parity_type(Parity_type), .Stop2(Stop2), .Data_valid(Data_valid), .Data(Data),
    .Data_ready(Data_ready), .Tx_out(Tx_out), .Busy(Busy), .Fifo_count(Fifo_count)
  );

  always #5 CLK = ~CLK;

  // Reference model: the FIFO is a queue of words and the line is a queue of per-cycle levels.
  logic [DW-1:0] m_fifo [$];
  bit            m_line [$];
  bit            m_push;

  function automatic void build_frame(input logic [DW-1:0] w);
    bit bits [$];
    int n;
    n = int'(Prescale) + 1;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (Parity_EN) bits.push_back(bit'(($countones(w) % 2) != 0) ^ Parity_type);
    bits.push_back(1'b1);
    if (Stop2) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < n; k++) m_line.push_back(bits[i]);
  endfunction

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      m_fifo.delete();
      m_line.delete();
    end else begin
      m_push = Data_valid && (m_fifo.size() < FD);
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && m_fifo.size() > 0) build_frame(m_fifo.pop_front());
      if (m_push) m_fifo.push_back(Data);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic checkModel();
    checkOutput("tx", 32'(Tx_out), 32'((m_line.size() > 0) ? m_line[0] : 1'b1));
    checkOutput("busy", 32'(Busy), 32'(m_line.size() > 0));
    checkOutput("count", 32'(Fifo_count), 32'(m_fifo.size()));
    checkOutput("ready", 32'(Data_ready), 32'(m_fifo.size() < FD));
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    checkModel();
  endtask

  task automatic applyStimulus(input logic [DW-1:0] w);
    bit rb;
    int g;
    g = 0;
    Data = w;
    Data_valid = 1'b1;
    do begin
      rb = Data_ready;
      tick();
      g++;
    end while (!rb && g < 1000);
    if (!rb) failNow("push_wait");
    Data_valid = 1'b0;
  endtask

  task automatic setCfg(input int pre, input bit pen, input bit ptype, input bit s2);
    Prescale = PW'(pre);
    Parity_EN = pen;
    Parity_type = ptype;
    Stop2 = s2;
  endtask

  task automatic waitBusy();
    int g;
    g = 0;
    while (!Busy && g < 50) begin tick(); g++; end
    if (!Busy) failNow("busy_wait");
  endtask

  task automatic busyRun(input int par_off, output int len, output bit par);
    len = 0;
    par = 1'b1;
    while (Busy && len < 3000) begin
      if (len == par_off) par = Tx_out;
      len++;
      tick();
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((Busy || Fifo_count != 0) && g < 3000) begin tick(); g++; end
    if (Busy || Fifo_count != 0) failNow("drain_wait");
  endtask

  typedef struct {
    int          pre;
    bit          pen;
    bit          ptype;
    bit          stop2;
    logic [7:0]  data;
    int          exp_len;
    bit          exp_par;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int len;
    bit par;
    int idx;
    int t;
    bit rb;
    bit full_seen;
    logic [DW-1:0] words [6];

    vecs[0] = '{3, 1'b1, 1'b0, 1'b0, 8'hA5, 44, 1'b0};
    vecs[1] = '{0, 1'b1, 1'b1, 1'b0, 8'h07, 11, 1'b0};
    vecs[2] = '{0, 1'b1, 1'b0, 1'b0, 8'h07, 11, 1'b1};
    vecs[3] = '{1, 1'b0, 1'b0, 1'b1, 8'h3C, 22, 1'b1};
    vecs[4] = '{2, 1'b1, 1'b1, 1'b1, 8'hFF, 36, 1'b1};
    vecs[5] = '{5, 1'b0, 1'b0, 1'b0, 8'h00, 60, 1'b1};

    $display("[TB] start");
    repeat (2) @(negedge CLK);
    checkOutput("reset_tx", 32'(Tx_out), 32'd1);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_count", 32'(Fifo_count), 32'd0);
    checkOutput("reset_ready", 32'(Data_ready), 32'd1);
    Reset = 1'b1;

    // Single frames from the vector table.
    foreach (vecs[i]) begin
      setCfg(vecs[i].pre, vecs[i].pen, vecs[i].ptype, vecs[i].stop2);
      applyStimulus(vecs[i].data);
      waitBusy();
      busyRun(9 * (vecs[i].pre + 1), len, par);
      checkOutput($sformatf("vec%0d_len", i), 32'(len), 32'(vecs[i].exp_len));
      if (vecs[i].pen) checkOutput($sformatf("vec%0d_parity", i), 32'(par), 32'(vecs[i].exp_par));
      tick();
    end

    // Back-to-back frames with no idle gap.
    setCfg(1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h3C);
    applyStimulus(8'hC3);
    waitBusy();
    busyRun(-1, len, par);
    checkOutput("b2b_len", 32'(len), 32'd44);
    drain();

    // Holding Data_valid with six words against a four-entry FIFO.
    setCfg(15, 1'b0, 1'b0, 1'b0);
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    idx = 0;
    t = -1;
    full_seen = 1'b0;
    Data = words[0];
    Data_valid = 1'b1;
    for (int c = 0; c < 400 && idx < 6; c++) begin
      rb = Data_ready;
      tick();
      if (t >= 0) t++;
      else if (Busy) t = 0;
      if (rb) begin
        if (idx == 5) checkOutput("word6_accept_cycle", 32'(t), 32'd161);
        idx++;
        if (idx < 6) Data = words[idx];
        else Data_valid = 1'b0;
      end
      if (idx == 5 && !full_seen) begin
        full_seen = 1'b1;
        checkOutput("full_count", 32'(Fifo_count), 32'd4);
        checkOutput("full_ready", 32'(Data_ready), 32'd0);
      end
    end
    if (idx < 6) failNow("word6_wait");
    Data_valid = 1'b0;
    drain();

    // Reset in the middle of data bit 3 with two words queued.
    setCfg(3, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h5A);
    applyStimulus(8'h81);
    applyStimulus(8'h7E);
    repeat (16) tick();
    checkOutput("pre_reset_count", 32'(Fifo_count), 32'd2);
    #1 Reset = 1'b0;
    #1;
    checkOutput("abort_tx", 32'(Tx_out), 32'd1);
    checkOutput("abort_busy", 32'(Busy), 32'd0);
    checkOutput("abort_count", 32'(Fifo_count), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      checkOutput("post_reset_quiet", 32'(Busy), 32'd0);
    end

    // Config changed mid-frame only affects the following frame.
    setCfg(3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h96);
    waitBusy();
    len = 0;
    while (Busy && len < 3000) begin
      if (len == 10) begin
        Prescale = 8'd7;
        Stop2 = 1'b1;
        Data = 8'h69;
        Data_valid = 1'b1;
      end
      if (len == 11) Data_valid = 1'b0;
      len++;
      tick();
    end
    checkOutput("cfg_change_len", 32'(len), 32'd128);
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0)
        setCfg(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
      Data_valid = ($urandom_range(0, 2) == 0);
      Data = DW'($urandom);
      tick();
    end
    Data_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
